// File: rtl/alu_request_arbiter.sv
// alu_request_arbiter
//
// Shares one combinational ALU between two requesters: requester 0 is the SPI
// operand path, requester 1 is the front-panel path. The arbiter grants one
// request at a time, alternating on contention. It drives the ALU operand and
// select lines and holds them for SETTLE_CYCLES cycles. It then captures the
// low result nibble and the flags, and pulses res_valid tagged with the owner.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   reqN_valid/_a/_b/_sel         request from requester N (held until ready)
//   reqN_ready                    handshake accepted this cycle (IDLE only)
//   alu_a, alu_b, alu_sel         operands/select driven to the shared ALU
//   alu_result, alu_z/c/v/s       combinational ALU response
//   res_value, res_flags          captured result nibble and flags {S,V,C,Z}
//   res_valid                     one-cycle completion strobe
//   res_owner                     requester index of last completed operation
//   busy                          controller is not idle
//
// Parameters:
//   WIDTH          operand width; ALU result is 2*WIDTH wide
//   SETTLE_CYCLES  ALU input hold time before capture, legal range 1..15

module alu_request_arbiter #(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic               clk,
    input  logic               reset,

    input  logic               req0_valid,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,
    input  logic [1:0]         req0_sel,
    output logic               req0_ready,

    input  logic               req1_valid,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,
    input  logic [1:0]         req1_sel,
    output logic               req1_ready,

    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [1:0]         alu_sel,
    input  logic [2*WIDTH-1:0] alu_result,
    input  logic               alu_z,
    input  logic               alu_c,
    input  logic               alu_v,
    input  logic               alu_s,

    output logic [WIDTH-1:0]   res_value,
    output logic [3:0]         res_flags,
    output logic               res_valid,
    output logic               res_owner,
    output logic               busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    // The counter starts at SETTLE_CYCLES-1 and captures when it reaches 0.
    // This gives exactly SETTLE_CYCLES cycles in SETTLE.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    logic [1:0] state;
    logic [3:0] settle_cnt;
    logic       cur_owner;    // requester being served right now
    logic       last_served;  // requester that completed most recently
    logic       grant0;
    logic       grant1;

    // The upper result bits are deliberately dropped; only the low nibble is shown.
    logic       unused_result_hi;
    assign unused_result_hi = ^alu_result[2*WIDTH-1:WIDTH];

    // Round-robin grant. It is offered only in IDLE, so ready can never be
    // high while an operation is in flight. On a tie, the requester that was
    // not served last wins.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == ST_IDLE && !reset) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_served;
                grant1 = !last_served;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign res_valid  = (state == ST_DONE);
    assign busy       = (state != ST_IDLE);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            settle_cnt  <= 4'd0;
            cur_owner   <= 1'b0;
            last_served <= 1'b1;  // makes requester 0 the first tie winner
            alu_a       <= '0;
            alu_b       <= '0;
            alu_sel     <= 2'b00;
            res_value   <= '0;
            res_flags   <= 4'b0000;
            res_owner   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant0 || grant1) begin
                        alu_a      <= grant1 ? req1_a   : req0_a;
                        alu_b      <= grant1 ? req1_b   : req0_b;
                        alu_sel    <= grant1 ? req1_sel : req0_sel;
                        cur_owner  <= grant1;
                        settle_cnt <= SETTLE_LOAD;
                        state      <= ST_SETTLE;
                    end
                end

                ST_SETTLE: begin
                    if (settle_cnt == 4'd0) begin
                        res_value   <= alu_result[WIDTH-1:0];
                        res_flags   <= {alu_s, alu_v, alu_c, alu_z};
                        res_owner   <= cur_owner;
                        last_served <= cur_owner;
                        state       <= ST_DONE;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
